// File: rtl/mem_burst_responder.sv
// Burst-protocol responder backed by an on-chip memory.
// It stands in for the DDR3 controller and follows the same cycle contract:
// the write data request leads the data by one cycle, read beats arrive a
// fixed latency after accept, and each burst ends with a one-cycle finish pulse.
module mem_burst_responder #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 25,
    parameter int BUSRT_BITS    = 10,
    parameter int DEPTH_BITS    = 12,
    parameter int RD_LATENCY    = 3
) (
    input  logic                     mem_clk,
    input  logic                     rst,
    input  logic                     rd_burst_req,
    input  logic [BUSRT_BITS-1:0]    rd_burst_len,
    input  logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic                     rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     rd_burst_finish,
    input  logic                     wr_burst_req,
    input  logic [BUSRT_BITS-1:0]    wr_burst_len,
    input  logic [ADDR_BITS-1:0]     wr_burst_addr,
    output logic                     wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic                     wr_burst_finish
);

    typedef enum logic [2:0] {
        IDLE,
        WR_BURST,
        WR_TAIL,
        RD_WAIT,
        RD_BURST,
        DONE
    } state_t;

    localparam logic [BUSRT_BITS-1:0] CNT_ONE  = 1;
    localparam logic [3:0]            WAIT_INI = 4'(RD_LATENCY - 2);

    state_t                  state_q, state_d;
    logic [BUSRT_BITS-1:0]   cnt_q, cnt_d;
    logic [3:0]              wait_q, wait_d;
    logic                    last_rd_q, last_rd_d;
    logic                    op_rd_q, op_rd_d;
    logic [DEPTH_BITS-1:0]   wptr_q, wptr_d;
    logic [DEPTH_BITS-1:0]   rptr_q, rptr_d;
    logic                    wr_cap_q;
    logic                    pick_rd;

    logic                    rd_valid_q;
    logic [MEM_DATA_BITS-1:0] rd_data_q;
    logic                    rd_finish_q;
    logic                    wr_req_q;
    logic                    wr_finish_q;

    logic [MEM_DATA_BITS-1:0] mem_q [2**DEPTH_BITS];

    // Upper address bits are deliberately ignored: the memory aliases across the space.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, rd_burst_addr[ADDR_BITS-1:DEPTH_BITS],
                                wr_burst_addr[ADDR_BITS-1:DEPTH_BITS]};

    // Next-state: arbitration in IDLE, beat/latency counting, pointer advance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        last_rd_d = last_rd_q;
        op_rd_d   = op_rd_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        pick_rd   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_burst_req || wr_burst_req) begin
                    // Contention goes to whichever side was not served last.
                    pick_rd   = rd_burst_req && (!wr_burst_req || !last_rd_q);
                    last_rd_d = pick_rd;
                    op_rd_d   = pick_rd;
                    if (pick_rd) begin
                        cnt_d   = rd_burst_len;
                        rptr_d  = rd_burst_addr[DEPTH_BITS-1:0];
                        wait_d  = WAIT_INI;
                        state_d = (rd_burst_len == '0) ? DONE : RD_WAIT;
                    end else begin
                        cnt_d   = wr_burst_len;
                        wptr_d  = wr_burst_addr[DEPTH_BITS-1:0];
                        state_d = (wr_burst_len == '0) ? DONE : WR_BURST;
                    end
                end
            end
            WR_BURST: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) state_d = WR_TAIL;
            end
            WR_TAIL:  state_d = DONE;
            RD_WAIT: begin
                if (wait_q == '0) state_d = RD_BURST;
                else              wait_d  = wait_q - 1'b1;
            end
            RD_BURST: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) state_d = DONE;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // Memory read is issued the cycle before each beat is presented.
        if (state_d == RD_BURST) rptr_d = rptr_q + 1'b1;
        if (wr_cap_q)            wptr_d = wptr_q + 1'b1;
    end

    // State, counters and registered outputs (derived from next state).
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wait_q      <= '0;
            last_rd_q   <= 1'b0;
            op_rd_q     <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            wr_cap_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_finish_q <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_finish_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            last_rd_q   <= last_rd_d;
            op_rd_q     <= op_rd_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            wr_cap_q    <= wr_req_q;
            rd_valid_q  <= (state_d == RD_BURST);
            rd_finish_q <= (state_d == DONE) &&  op_rd_d;
            wr_req_q    <= (state_d == WR_BURST);
            wr_finish_q <= (state_d == DONE) && !op_rd_d;
        end
    end

    // Read data register: memory word for each beat, zero otherwise.
    always_ff @(posedge mem_clk) begin
        if (rst)                        rd_data_q <= '0;
        else if (state_d == RD_BURST)   rd_data_q <= mem_q[rptr_q];
        else                            rd_data_q <= '0;
    end

    // Memory array: no reset, so contents survive rst.
    always_ff @(posedge mem_clk) begin
        if (wr_cap_q && !rst) mem_q[wptr_q] <= wr_burst_data;
    end

    assign rd_burst_data_valid = rd_valid_q;
    assign rd_burst_data       = rd_data_q;
    assign rd_burst_finish     = rd_finish_q;
    assign wr_burst_data_req   = wr_req_q;
    assign wr_burst_finish     = wr_finish_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Scoreboard bench for mem_burst_responder: requester tasks push expected
// beats/pulses with their cycle numbers, a monitor pops and compares.
module tb_mem_burst_responder;

    localparam int DW  = 64;
    localparam int AW  = 25;
    localparam int LW  = 10;
    localparam int RDL = 3;

    logic          mem_clk = 1'b0;
    logic          rst;
    logic          rd_burst_req;
    logic [LW-1:0] rd_burst_len;
    logic [AW-1:0] rd_burst_addr;
    logic          rd_burst_data_valid;
    logic [DW-1:0] rd_burst_data;
    logic          rd_burst_finish;
    logic          wr_burst_req;
    logic [LW-1:0] wr_burst_len;
    logic [AW-1:0] wr_burst_addr;
    logic          wr_burst_data_req;
    logic [DW-1:0] wr_burst_data = '0;
    logic          wr_burst_finish;

    mem_burst_responder #(
        .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BUSRT_BITS(LW),
        .DEPTH_BITS(10), .RD_LATENCY(RDL)
    ) dut (
        .mem_clk(mem_clk), .rst(rst),
        .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len),
        .rd_burst_addr(rd_burst_addr), .rd_burst_data_valid(rd_burst_data_valid),
        .rd_burst_data(rd_burst_data), .rd_burst_finish(rd_burst_finish),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
        .wr_burst_addr(wr_burst_addr), .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_data(wr_burst_data), .wr_burst_finish(wr_burst_finish)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } ev_t;

    ev_t         q_rd[$];
    int          q_wreq[$];
    int          q_wfin[$];
    int          q_rfin[$];
    logic [63:0] wq[$];

    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    logic mon_on = 1'b0;
    logic drv_next = 1'b0;

    always @(posedge mem_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic flag(input string nm);
        n_tot++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    // Write-data driver: one cycle after a sampled data request, present the next word.
    always @(negedge mem_clk) drv_next = wr_burst_data_req;
    always @(posedge mem_clk) begin
        #1;
        if (drv_next) wr_burst_data = (wq.size() > 0) ? wq.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    end

    // Monitor: every DUT output event must match the head of its queue.
    always @(negedge mem_clk) begin
        if (mon_on) begin
            if (rd_burst_data_valid) begin
                if (q_rd.size() == 0) flag("rd_valid_extra");
                else begin
                    ev_t e;
                    e = q_rd.pop_front();
                    chk("rd_beat_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rd_beat_data", rd_burst_data, e.data);
                end
            end
            if (wr_burst_data_req) begin
                if (q_wreq.size() == 0) flag("wr_data_req_extra");
                else chk("wr_data_req_cycle", 64'(cyc), 64'(q_wreq.pop_front()));
            end
            if (rd_burst_finish) begin
                if (q_rfin.size() == 0) flag("rd_finish_extra");
                else chk("rd_finish_cycle", 64'(cyc), 64'(q_rfin.pop_front()));
            end
            if (wr_burst_finish) begin
                if (q_wfin.size() == 0) flag("wr_finish_extra");
                else chk("wr_finish_cycle", 64'(cyc), 64'(q_wfin.pop_front()));
            end
            if (rd_burst_data_valid && wr_burst_data_req) flag("valid_and_data_req");
            if (rd_burst_finish && wr_burst_finish)       flag("both_finish");
        end
    end

    // Write burst of len words base+i; dly = cycles until the DUT is expected to accept.
    task automatic do_write(input logic [AW-1:0] addr, input int len,
                            input logic [63:0] base, input int dly);
        int  a;
        bit  seen;
        a = cyc + dly;
        for (int i = 0; i < len; i++) begin
            wq.push_back(base + 64'(i));
            q_wreq.push_back(a + 1 + i);
        end
        q_wfin.push_back((len == 0) ? a + 1 : a + len + 2);
        wr_burst_addr = addr;
        wr_burst_len  = LW'(len);
        wr_burst_req  = 1'b1;
        seen = 0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            tick();
            if (wr_burst_finish) seen = 1;
        end
        if (!seen) flag("wr_finish_timeout");
        wr_burst_req = 1'b0;
    endtask

    // Read burst expecting base+i per beat.
    task automatic do_read(input logic [AW-1:0] addr, input int len,
                           input logic [63:0] base, input int dly);
        int  a;
        bit  seen;
        a = cyc + dly;
        for (int i = 0; i < len; i++) q_rd.push_back('{a + RDL + i, base + 64'(i)});
        q_rfin.push_back((len == 0) ? a + 1 : a + RDL + len);
        rd_burst_addr = addr;
        rd_burst_len  = LW'(len);
        rd_burst_req  = 1'b1;
        seen = 0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            tick();
            if (rd_burst_finish) seen = 1;
        end
        if (!seen) flag("rd_finish_timeout");
        rd_burst_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst = 1'b1;
        rd_burst_req = 0; rd_burst_len = '0; rd_burst_addr = '0;
        wr_burst_req = 0; wr_burst_len = '0; wr_burst_addr = '0;
        repeat (3) tick();
        chk("reset_rd_valid",  64'(rd_burst_data_valid), 64'd0);
        chk("reset_rd_data",   rd_burst_data,            64'd0);
        chk("reset_rd_finish", 64'(rd_burst_finish),     64'd0);
        chk("reset_wr_req",    64'(wr_burst_data_req),   64'd0);
        chk("reset_wr_finish", 64'(wr_burst_finish),     64'd0);
        rst = 1'b0;
        mon_on = 1'b1;
        tick();

        // 1: write 1..4 at 0x10, read back
        do_write(25'h10, 4, 64'd1, 0);
        tick();
        do_read(25'h10, 4, 64'd1, 0);

        // re-reset so arbitration history restarts; memory must survive
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // 2a: both requests after reset -> read first, write accepted after read DONE
        fork
            do_read(25'h10, 2, 64'd1, 0);
            do_write(25'h200, 2, 64'd100, RDL + 2 + 1);
        join
        tick();
        // 2b: lone read, then both -> write wins this time
        do_read(25'h200, 2, 64'd100, 0);
        tick();
        fork
            do_write(25'h300, 2, 64'd200, 0);
            do_read(25'h10, 1, 64'd1, 2 + 2 + 1);
        join
        tick();

        // 3: wrap at top of memory and upper-address aliasing
        do_write(25'h3FE, 4, 64'hA, 0);
        tick();
        do_read(25'h000, 2, 64'hC, 0);
        tick();
        do_read(25'h1003FE, 2, 64'hA, 0);
        tick();

        // 4: zero-length write
        do_write(25'h50, 0, 64'd0, 0);
        tick();

        // 5: reset during beat 3 of an 8-beat read
        do_write(25'h100, 8, 64'h5000, 0);
        tick();
        s = cyc;
        for (int i = 0; i < 3; i++) q_rd.push_back('{s + RDL + i, 64'h5000 + 64'(i)});
        rd_burst_addr = 25'h100;
        rd_burst_len  = LW'(8);
        rd_burst_req  = 1'b1;
        while (cyc < s + RDL + 2) tick();
        rst = 1'b1;
        rd_burst_req = 1'b0;
        tick();
        chk("abort_rd_valid",  64'(rd_burst_data_valid), 64'd0);
        chk("abort_rd_finish", 64'(rd_burst_finish),     64'd0);
        rst = 1'b0;
        tick();
        do_read(25'h100, 8, 64'h5000, 0);
        tick();

        // 6: back-to-back 64-beat writes, then read both back
        do_write(25'h40, 64, 64'h1000, 0);
        tick();
        do_write(25'h80, 64, 64'h2000, 0);
        tick();
        do_read(25'h40, 64, 64'h1000, 0);
        tick();
        do_read(25'h80, 64, 64'h2000, 0);

        repeat (5) tick();
        chk("rd_queue_drained",   64'(q_rd.size()),   64'd0);
        chk("wreq_queue_drained", 64'(q_wreq.size()), 64'd0);
        chk("rfin_queue_drained", 64'(q_rfin.size()), 64'd0);
        chk("wfin_queue_drained", 64'(q_wfin.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
